// File: rtl/arb2x1.sv
// Two-channel round-robin arbiter driving a 2:1 mux select, with registered outputs.
// Optional forced release after MAX_HOLD unacknowledged cycles: define ARB2X1_TIMEOUT_EN.
module arb2x1 #(
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic REQ0,
   input  logic REQ1,
   input  logic ACK,
   output logic S,
   output logic GNT0,
   output logic GNT1,
   output logic VALID,
   output logic TIMEOUT
);

   typedef enum logic [1:0] {IDLE, GNT_0, GNT_1} state_t;

   localparam logic [7:0] HC_MAX = 8'(MAX_HOLD - 1);

   state_t     state_q, state_d;
   logic       last_q, last_d;
   logic [7:0] hc_q, hc_d;
   logic       to_d;
   logic       s_d, gnt0_d, gnt1_d, valid_d;

   logic       cur;
   logic       req_cur, req_oth;
   state_t     oth_st;

   assign cur     = (state_q == GNT_1);
   assign req_cur = cur ? REQ1 : REQ0;
   assign req_oth = cur ? REQ0 : REQ1;
   assign oth_st  = cur ? GNT_0 : GNT_1;

   // Next-state, tie-break pointer and hold counter
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      hc_d    = hc_q;
      to_d    = 1'b0;
      case (state_q)
         IDLE: begin
            hc_d = 8'd0;
            if (REQ0 && REQ1)
               state_d = last_q ? GNT_0 : GNT_1;
            else if (REQ0)
               state_d = GNT_0;
            else if (REQ1)
               state_d = GNT_1;
         end
         GNT_0, GNT_1: begin
            if (ACK) begin
               last_d  = cur;
               hc_d    = 8'd0;
               state_d = req_oth ? oth_st : (req_cur ? state_q : IDLE);
            end else if (!req_cur) begin
               last_d  = cur;
               hc_d    = 8'd0;
               state_d = req_oth ? oth_st : IDLE;
            end
`ifdef ARB2X1_TIMEOUT_EN
            else if (hc_q == HC_MAX) begin
               // Forced release; with no competitor the same channel is re-granted afresh
               last_d  = cur;
               hc_d    = 8'd0;
               to_d    = 1'b1;
               state_d = req_oth ? oth_st : state_q;
            end
`endif
            else if (hc_q != HC_MAX) begin
               hc_d = hc_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            hc_d    = 8'd0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they line up with state_q after the edge
   always_comb begin
      s_d     = S;
      gnt0_d  = 1'b0;
      gnt1_d  = 1'b0;
      valid_d = 1'b0;
      case (state_d)
         GNT_0: begin
            s_d     = 1'b0;
            gnt0_d  = 1'b1;
            valid_d = 1'b1;
         end
         GNT_1: begin
            s_d     = 1'b1;
            gnt1_d  = 1'b1;
            valid_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         hc_q    <= 8'd0;
         S       <= 1'b0;
         GNT0    <= 1'b0;
         GNT1    <= 1'b0;
         VALID   <= 1'b0;
         TIMEOUT <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         hc_q    <= hc_d;
         S       <= s_d;
         GNT0    <= gnt0_d;
         GNT1    <= gnt1_d;
         VALID   <= valid_d;
         TIMEOUT <= to_d;
      end
   end

endmodule

// File: tb/tb_arb2x1.sv
// Directed and randomized bench for arb2x1 against a transaction-level reference model.
// Honours ARB2X1_TIMEOUT_EN the same way as the design.
module tb_arb2x1;

   localparam int MAX_HOLD = 4;
`ifdef ARB2X1_TIMEOUT_EN
   localparam bit TEN = 1'b1;
`else
   localparam bit TEN = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RST, REQ0, REQ1, ACK;
   logic S, GNT0, GNT1, VALID, TIMEOUT;

   int vectors     = 0;
   int miscompares = 0;

   // reference model: owner -1 = nobody, cnt = unacknowledged cycles beyond the first
   int m_owner, m_last, m_cnt, m_s, m_to;

   arb2x1 #(.MAX_HOLD(MAX_HOLD)) dut (
      .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1), .ACK(ACK),
      .S(S), .GNT0(GNT0), .GNT1(GNT1), .VALID(VALID), .TIMEOUT(TIMEOUT)
   );

   always #5 CLK = ~CLK;

   function automatic void model_reset();
      m_owner = -1;
      m_last  = 1;
      m_cnt   = 0;
      m_s     = 0;
      m_to    = 0;
   endfunction

   function automatic void model_edge(input bit r0, input bit r1, input bit a);
      int n, o;
      bit rn, ro;
      m_to = 0;
      if (m_owner < 0) begin
         m_cnt = 0;
         if (r0 && r1)  m_owner = 1 - m_last;
         else if (r0)   m_owner = 0;
         else if (r1)   m_owner = 1;
      end else begin
         n  = m_owner;
         o  = 1 - n;
         rn = (n == 1) ? r1 : r0;
         ro = (n == 1) ? r0 : r1;
         if (a || !rn) begin
            m_last = n;
            m_cnt  = 0;
            if (ro)           m_owner = o;
            else if (a && rn) m_owner = n;
            else              m_owner = -1;
         end else if (TEN && m_cnt == MAX_HOLD - 1) begin
            m_last  = n;
            m_to    = 1;
            m_cnt   = 0;
            m_owner = ro ? o : n;
         end else if (m_cnt < MAX_HOLD - 1) begin
            m_cnt++;
         end
      end
      if (m_owner >= 0) m_s = m_owner;
   endfunction

   task automatic check(input string tag);
      logic [4:0] obs, exp;
      obs = {GNT0, GNT1, VALID, S, TIMEOUT};
      exp = {m_owner == 0, m_owner == 1, m_owner >= 0, m_s == 1, m_to == 1};
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed={g0,g1,v,s,to}=%b expected=%b", tag, obs, exp);
      end
      vectors++;
      assert (!(GNT0 === 1'b1 && GNT1 === 1'b1)) else begin
         miscompares++;
         $error("FAIL %s_excl observed g0=%b g1=%b expected not both 1", tag, GNT0, GNT1);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step(input bit r0, input bit r1, input bit a, input string tag);
      REQ0 = r0;
      REQ1 = r1;
      ACK  = a;
      @(posedge CLK);
      model_edge(r0, r1, a);
      #1;
      check(tag);
   endtask

   initial begin
      RST = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0; ACK = 1'b0;
      model_reset();
      #12;
      check("reset");
      @(negedge CLK);
      RST = 1'b0;

      // both requesting with ACK every cycle: strict alternation starting with channel 0
      for (int i = 0; i < 8; i++) begin
         step(1, 1, 1, "alternate");
         check_bit("alt_s", S, logic'(i % 2));
      end

      // channel 1 alone, two unacked cycles, then ACK with the request dropped
      step(0, 0, 1, "drain");
      step(0, 0, 0, "idle");
      step(0, 1, 0, "r1_grant");
      step(0, 1, 0, "r1_hold1");
      step(0, 1, 0, "r1_hold2");
      check_bit("r1_held_gnt1", GNT1, 1'b1);
      step(0, 0, 1, "r1_ack_idle");
      check_bit("r1_idle_valid", VALID, 1'b0);
      step(0, 0, 1, "ack_in_idle");

      // both requesting, never acknowledged: forced release or indefinite hold
      for (int i = 0; i < 24; i++) begin
         step(1, 1, 0, "hold");
         if (i == 21) begin
            check_bit("hold_gnt0_late", GNT0, TEN ? 1'b0 : 1'b1);
            check_bit("hold_s_late", S, TEN ? 1'b1 : 1'b0);
         end
      end

      // abandon of channel 0 while channel 1 waits
      step(0, 0, 1, "drain2");
      step(0, 0, 0, "idle2");
      step(1, 0, 0, "g0");
      step(0, 1, 0, "abandon_to_g1");
      check_bit("abandon_s", S, 1'b1);
      step(0, 0, 0, "abandon_idle");

      // reset between edges mid-grant
      step(1, 0, 0, "pre_rst_grant");
      #3;
      RST = 1'b1;
      model_reset();
      #1;
      check("async_rst");
      #2;
      RST = 1'b0;
      step(1, 1, 0, "post_rst_first");
      check_bit("post_rst_gnt0", GNT0, 1'b1);

      // randomized traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 59) == 0) begin
            #2;
            RST = 1'b1;
            model_reset();
            #1;
            check("rand_rst");
            #1;
            RST = 1'b0;
         end
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 2) == 0), "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
